// File: rtl/i2c_pkg.sv
// i2c_pkg: status codes, FSM encoding and bus widths shared by the I2C master arbiter.
package i2c_pkg;
   localparam int AW = 7;
   localparam int DW = 8;
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester-side and master-side signals of the I2C master arbiter.
interface i2c_master_arbiter_if #(parameter int NREQ = 4);
   import i2c_pkg::*;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_rw;
   logic [AW*NREQ-1:0] req_addr;
   logic [DW*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [DW-1:0]      rdata;
   logic [1:0]         err;
   logic               m_enable;
   logic               m_rw;
   logic [AW-1:0]      m_addr;
   logic [DW-1:0]      m_wdata;
   logic [DW-1:0]      m_rdata;
   logic               m_error;
   logic               m_busy;
   modport master (
      input  req, req_rw, req_addr, req_wdata, m_rdata, m_error, m_busy,
      output gnt, done, rdata, err, m_enable, m_rw, m_addr, m_wdata
   );
   modport slave (
      output req, req_rw, req_addr, req_wdata, m_rdata, m_error, m_busy,
      input  gnt, done, rdata, err, m_enable, m_rw, m_addr, m_wdata
   );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; searches upward from last_i+1 and returns one-hot winner and index.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   always_comb begin
      logic [IW-1:0] j;
      j = '0;
      idx_o = '0;
      // walk offsets from farthest to nearest so the nearest requester wins
      for (int k = N; k >= 1; k--) begin
         j = IW'((int'(last_i) + k) % N);
         idx_o = req_i[j] ? j : idx_o;
      end
      any_o = |req_i;
      gnt_o = any_o ? N'(1) << idx_o : '0;
   end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: shares one single-byte I2C master among NREQ requesters with round-robin
// grants, launch/run watchdogs and per-transaction status return.
module i2c_master_arbiter #(
   parameter int NREQ     = 4,
   parameter int TIMEOUT  = 1023,
   parameter int START_TO = 7
) (
   input logic clk_i,
   input logic rst_i,
   i2c_master_arbiter_if.master bus
);
   import i2c_pkg::*;
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   last_q, last_d, gidx_q, gidx_d, pick_idx;
   logic [NREQ-1:0] gnt_q, gnt_d, pick_gnt;
   logic            pick_any, rw_q, rw_d, nack_q, nack_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]      err_q, err_d;
   rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .req_i (bus.req),
      .last_i(last_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + CW'(cnt_q != '1);
      last_d = last_q;
      gidx_d = gidx_q;
      gnt_d = gnt_q;
      rw_d = rw_q;
      nack_d = nack_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d = err_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            nack_d = 1'b0;
            if (pick_any) begin
               state_d = LAUNCH;
               gnt_d = pick_gnt;
               gidx_d = pick_idx;
               rw_d = bus.req_rw[pick_idx];
               addr_d = bus.req_addr[int'(pick_idx)*AW +: AW];
               wdata_d = bus.req_wdata[int'(pick_idx)*DW +: DW];
            end
         end
         LAUNCH: begin
            if (bus.m_busy) begin
               state_d = RUN;
               cnt_d = '0;
            end else if (cnt_q == CW'(START_TO)) begin
               state_d = RESP;
               err_d = ERR_TIMEOUT;
               rdata_d = '0;
            end
         end
         RUN: begin
            nack_d = nack_q | bus.m_error;
            // a BUSY fall on the timeout cycle still counts as completion
            if (!bus.m_busy) begin
               state_d = RESP;
               rdata_d = rw_q ? '0 : bus.m_rdata;
               err_d = nack_d ? ERR_NACK : ERR_OK;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               state_d = RESP;
               err_d = ERR_TIMEOUT;
               rdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d = '0;
            last_d = gidx_q;
         end
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         last_q <= IW'(NREQ - 1);
         gidx_q <= '0;
         gnt_q <= '0;
         rw_q <= 1'b0;
         nack_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q <= ERR_OK;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         last_q <= last_d;
         gidx_q <= gidx_d;
         gnt_q <= gnt_d;
         rw_q <= rw_d;
         nack_q <= nack_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
   end
   assign bus.gnt = gnt_q;
   assign bus.done = (state_q == RESP) ? gnt_q : '0;
   assign bus.rdata = rdata_q;
   assign bus.err = err_q;
   assign bus.m_enable = (state_q == LAUNCH);
   assign bus.m_rw = rw_q;
   assign bus.m_addr = addr_q;
   assign bus.m_wdata = wdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: randomized rounds against a round-robin reference model, with a scoreboard
// fed at stimulus time and drained by a monitor on launches and DONE pulses.
module tb_i2c_master_arbiter;
   import i2c_pkg::*;
   localparam int NREQ = 4;
   localparam int TIMEOUT = 1023;
   localparam int START_TO = 7;
   typedef struct {int mode; int dly; int len; logic [7:0] rd;} beh_t;
   typedef struct {int idx; logic rw; logic [6:0] addr; logic [7:0] wdata; logic [7:0] rdata; logic [1:0] err; int enlen;} txn_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   i2c_master_arbiter_if #(.NREQ(NREQ)) bus();
   i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .START_TO(START_TO)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );
   txn_t exp_q[$];
   beh_t beh_q[$];
   beh_t pre_q[$];
   int errors = 0;
   int checks = 0;
   int last_model = NREQ - 1;
   int stuck_budget = 2;
   logic       p_rw[NREQ];
   logic [6:0] p_addr[NREQ];
   logic [7:0] p_wd[NREQ];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic beh_t rand_beh();
      beh_t b;
      int r;
      r = $urandom_range(0, 9);
      b.mode = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
      if (b.mode == 3 && stuck_budget == 0) b.mode = 0;
      if (b.mode == 3) stuck_budget--;
      b.dly = $urandom_range(0, 6);
      b.len = $urandom_range(3, 30);
      b.rd = 8'($urandom);
      return b;
   endfunction
   function automatic beh_t mk(input int mode, input int dly, input int len, input logic [7:0] rd);
      beh_t b;
      b.mode = mode;
      b.dly = dly;
      b.len = len;
      b.rd = rd;
      return b;
   endfunction
   task automatic drive_payload();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_rw[i] = p_rw[i];
         bus.req_addr[i*AW +: AW] = p_addr[i];
         bus.req_wdata[i*DW +: DW] = p_wd[i];
      end
   endtask
   task automatic rand_payload();
      for (int i = 0; i < NREQ; i++) begin
         p_rw[i] = 1'($urandom);
         p_addr[i] = 7'($urandom);
         p_wd[i] = 8'($urandom);
      end
   endtask
   task automatic push_txn(input int j, input beh_t b);
      txn_t t;
      t.idx = j;
      t.rw = p_rw[j];
      t.addr = p_addr[j];
      t.wdata = p_wd[j];
      t.err = (b.mode == 0) ? ERR_OK : (b.mode == 1) ? ERR_NACK : ERR_TIMEOUT;
      t.rdata = (b.mode >= 2 || p_rw[j]) ? 8'h00 : b.rd;
      t.enlen = (b.mode == 2) ? START_TO + 1 : b.dly + 1;
      exp_q.push_back(t);
      beh_q.push_back(b);
   endtask
   // every requester in mask raises REQ together and drops it on its reps-th DONE
   task automatic run_round(input logic [NREQ-1:0] mask, input int reps);
      int ndone[NREQ];
      int j;
      int lastp;
      beh_t b;
      lastp = last_model;
      for (int r = 0; r < reps; r++) begin
         for (int k = 1; k <= NREQ; k++) begin
            j = (last_model + k) % NREQ;
            if (mask[j]) begin
               if (pre_q.size() > 0) b = pre_q.pop_front();
               else b = rand_beh();
               push_txn(j, b);
               lastp = j;
            end
         end
      end
      last_model = lastp;
      for (int i = 0; i < NREQ; i++) ndone[i] = 0;
      drive_payload();
      bus.req = mask;
      for (int c = 0; c < 20000 && (bus.req != 0 || exp_q.size() != 0); c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.done[i]) begin
               ndone[i]++;
               if (ndone[i] >= reps) bus.req[i] = 1'b0;
            end else if (reps == 1 && bus.gnt[i]) begin
               bus.req_rw[i] = 1'($urandom);
               bus.req_addr[i*AW +: AW] = 7'($urandom);
               bus.req_wdata[i*DW +: DW] = 8'($urandom);
            end
         end
      end
      if (bus.req != 0 || exp_q.size() != 0) begin
         chk("round_timeout", 32'(exp_q.size()), 0);
         exp_q.delete();
         beh_q.delete();
         bus.req = '0;
      end
      repeat (3) @(negedge clk);
   endtask
   initial begin : master_model
      beh_t b;
      bus.m_busy = 1'b0;
      bus.m_error = 1'b0;
      bus.m_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && bus.m_enable && beh_q.size() > 0) begin
            b = beh_q.pop_front();
            if (b.mode == 2) begin
               for (int k = 0; k < 40 && bus.m_enable; k++) @(negedge clk);
            end else begin
               repeat (b.dly) @(negedge clk);
               bus.m_busy = 1'b1;
               if (b.mode == 3) begin
                  for (int k = 0; k < 3000 && bus.gnt != 0; k++) @(negedge clk);
               end else begin
                  for (int k = 0; k < b.len; k++) begin
                     @(negedge clk);
                     if (b.mode == 1 && k >= 1) bus.m_error = 1'b1;
                  end
               end
               bus.m_busy = 1'b0;
               bus.m_error = 1'b0;
               bus.m_rdata = b.rd;
            end
         end
      end
   end
   initial begin : monitor
      logic en_prev;
      int en_cnt;
      txn_t t;
      en_prev = 1'b0;
      en_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            en_prev = 1'b0;
            en_cnt = 0;
         end else begin
            if (bus.m_enable && !en_prev) begin
               en_cnt = 0;
               if (exp_q.size() == 0) chk("unexpected_launch", 32'(bus.gnt), 0);
               else begin
                  t = exp_q[0];
                  chk("gnt", 32'(bus.gnt), 32'(NREQ'(1) << t.idx));
                  chk("m_addr", 32'(bus.m_addr), 32'(t.addr));
                  chk("m_wdata", 32'(bus.m_wdata), 32'(t.wdata));
                  chk("m_rw", 32'(bus.m_rw), 32'(t.rw));
               end
            end
            if (bus.m_enable) en_cnt++;
            else if (en_prev && exp_q.size() > 0) chk("enable_len", 32'(en_cnt), 32'(exp_q[0].enlen));
            if (|bus.done) begin
               if (exp_q.size() == 0) chk("unexpected_done", 32'(bus.done), 0);
               else begin
                  t = exp_q.pop_front();
                  chk("done", 32'(bus.done), 32'(NREQ'(1) << t.idx));
                  chk("rdata", 32'(bus.rdata), 32'(t.rdata));
                  chk("err", 32'(bus.err), 32'(t.err));
               end
            end
            en_prev = bus.m_enable;
         end
      end
   end
   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin : stimulus
      bus.req = '0;
      bus.req_rw = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_m_enable", 32'(bus.m_enable), 0);
      chk("rst_m_rw", 32'(bus.m_rw), 0);
      chk("rst_m_addr", 32'(bus.m_addr), 0);
      chk("rst_m_wdata", 32'(bus.m_wdata), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rand_payload();
      p_rw[2] = 1'b1;
      p_addr[2] = 7'h50;
      p_wd[2] = 8'hA5;
      pre_q.push_back(mk(0, 2, 20, 8'h99));
      run_round(4'b0100, 1);
      rand_payload();
      run_round(4'b1111, 3);
      rand_payload();
      p_rw[1] = 1'b0;
      p_addr[1] = 7'h3C;
      pre_q.push_back(mk(0, 1, 10, 8'h7E));
      run_round(4'b0010, 1);
      rand_payload();
      pre_q.push_back(mk(1, 0, 8, 8'h55));
      pre_q.push_back(mk(0, 3, 5, 8'h66));
      run_round(4'b1001, 1);
      rand_payload();
      pre_q.push_back(mk(2, 0, 0, 8'h00));
      run_round(4'b0001, 1);
      pre_q.push_back(mk(3, 0, 0, 8'h44));
      run_round(4'b0001, 1);
      for (int r = 0; r < 12; r++) begin
         rand_payload();
         run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, 2));
      end
      rand_payload();
      drive_payload();
      push_txn(1, mk(3, 1, 0, 8'h00));
      bus.req = 4'b0010;
      for (int c = 0; c < 100 && !(bus.gnt[1] && !bus.m_enable); c++) @(negedge clk);
      chk("reset_reached_run", 32'(bus.gnt[1] && !bus.m_enable), 1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(bus.gnt), 0);
      chk("arst_m_enable", 32'(bus.m_enable), 0);
      chk("arst_done", 32'(bus.done), 0);
      chk("arst_err", 32'(bus.err), 0);
      exp_q.delete();
      bus.req = '0;
      last_model = NREQ - 1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rand_payload();
      run_round(4'b1010, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
